// File: rtl/branch_resolve_unit.sv
// Resolves RV32 conditional branches from SUB compare flags into a registered result with a 1-entry skid buffer.
// Optional statistics counters are built when BRU_STATS_EN is defined.
module branch_resolve_unit #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_funct3,
  input  logic             in_of,
  input  logic             in_zf,
  input  logic             in_nf,
  input  logic             in_cf,
  input  logic [XLEN-1:0]  in_pc,
  input  logic [XLEN-1:0]  in_imm,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_taken,
  output logic [XLEN-1:0]  out_target,
  output logic [XLEN-1:0]  out_next_pc,
  output logic             out_illegal,
  output logic [CNT_W-1:0] stat_total,
  output logic [CNT_W-1:0] stat_taken
);

  typedef struct packed {
    logic            taken;
    logic            illegal;
    logic [XLEN-1:0] target;
    logic [XLEN-1:0] next_pc;
  } entry_t;

  entry_t          w_new;
  logic            w_cond;
  logic            w_illegal;
  logic [XLEN-1:0] w_target;
  logic [XLEN-1:0] w_pc4;
  logic            w_in_fire;
  logic            w_out_fire;

  entry_t r_out;
  entry_t r_skid;
  logic   r_out_valid;
  logic   r_skid_valid;

  always_comb begin
    w_cond    = 1'b0;
    w_illegal = 1'b0;
    case (in_funct3)
      3'b000:  w_cond = in_zf;
      3'b001:  w_cond = ~in_zf;
      3'b100:  w_cond = in_nf ^ in_of;
      3'b101:  w_cond = ~(in_nf ^ in_of);
      3'b110:  w_cond = ~in_cf;
      3'b111:  w_cond = in_cf;
      default: w_illegal = 1'b1;
    endcase
    w_target      = in_pc + in_imm;
    w_pc4         = in_pc + XLEN'(4);
    w_new.taken   = w_cond;
    w_new.illegal = w_illegal;
    w_new.target  = w_target;
    w_new.next_pc = w_cond ? w_target : w_pc4;
  end

  assign in_ready   = ~r_skid_valid;
  assign w_in_fire  = in_valid & ~r_skid_valid;
  assign w_out_fire = r_out_valid & out_ready;

  // A full skid implies a valid output, so the skid branch only runs when the output fires.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid  <= 1'b0;
      r_skid_valid <= 1'b0;
      r_out        <= '0;
      r_skid       <= '0;
    end else if (flush) begin
      r_out_valid  <= 1'b0;
      r_skid_valid <= 1'b0;
    end else if (r_out_valid && !out_ready) begin
      if (w_in_fire) begin
        r_skid       <= w_new;
        r_skid_valid <= 1'b1;
      end
    end else if (r_skid_valid) begin
      r_out        <= r_skid;
      r_skid_valid <= 1'b0;
    end else begin
      r_out_valid <= w_in_fire;
      if (w_in_fire) begin
        r_out <= w_new;
      end
    end
  end

  assign out_valid   = r_out_valid;
  assign out_taken   = r_out.taken;
  assign out_illegal = r_out.illegal;
  assign out_target  = r_out.target;
  assign out_next_pc = r_out.next_pc;

`ifdef BRU_STATS_EN
  logic [CNT_W-1:0] r_stat_total;
  logic [CNT_W-1:0] r_stat_taken;

  // Flushed entries are never counted, even if the consumer accepts in the flush cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stat_total <= '0;
      r_stat_taken <= '0;
    end else if (!flush && w_out_fire && !r_out.illegal) begin
      if (r_stat_total != '1) begin
        r_stat_total <= r_stat_total + 1'b1;
      end
      if (r_out.taken && (r_stat_taken != '1)) begin
        r_stat_taken <= r_stat_taken + 1'b1;
      end
    end
  end

  assign stat_total = r_stat_total;
  assign stat_taken = r_stat_taken;
`else
  logic w_unused_fire;
  assign w_unused_fire = w_out_fire;
  assign stat_total    = '0;
  assign stat_taken    = '0;
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Self-checking bench for branch_resolve_unit: directed scenarios plus randomized traffic against a queue model.
module tb_branch_resolve_unit;
  localparam int XLEN  = 32;
  localparam int CNT_W = 32;
`ifdef BRU_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst, flush, in_valid, in_ready;
  logic [2:0]       in_funct3;
  logic             in_of, in_zf, in_nf, in_cf;
  logic [XLEN-1:0]  in_pc, in_imm;
  logic             out_valid, out_ready, out_taken, out_illegal;
  logic [XLEN-1:0]  out_target, out_next_pc;
  logic [CNT_W-1:0] stat_total, stat_taken;

  always #5 clk = ~clk;

  branch_resolve_unit #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_funct3(in_funct3),
    .in_of(in_of), .in_zf(in_zf), .in_nf(in_nf), .in_cf(in_cf),
    .in_pc(in_pc), .in_imm(in_imm),
    .out_valid(out_valid), .out_ready(out_ready), .out_taken(out_taken),
    .out_target(out_target), .out_next_pc(out_next_pc), .out_illegal(out_illegal),
    .stat_total(stat_total), .stat_taken(stat_taken)
  );

  typedef struct {
    logic        taken;
    logic        illegal;
    logic [31:0] target;
    logic [31:0] next_pc;
  } exp_t;

  exp_t             q[$];
  exp_t             cur_exp;
  logic [CNT_W-1:0] m_total, m_taken;
  int               checks = 0;
  int               failures = 0;

  // Model: entries accepted wait in order; at most two are held (output + skid).
  task automatic tick();
    bit inf, outf;
    inf  = in_valid && (q.size() < 2);
    outf = (q.size() > 0) && out_ready;
    if (rst) begin
      q.delete();
      m_total = '0;
      m_taken = '0;
    end else if (flush) begin
      q.delete();
    end else begin
      if (outf) begin
        if (!q[0].illegal) begin
          if (m_total != '1) m_total = m_total + 1'b1;
          if (q[0].taken && m_taken != '1) m_taken = m_taken + 1'b1;
        end
        void'(q.pop_front());
      end
      if (inf) q.push_back(cur_exp);
    end
    @(posedge clk);
    #1;
  endtask

  // Derives flags from a real subtraction and the expectation from direct comparisons of a and b.
  task automatic set_req_ab(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] pc, input logic [31:0] imm);
    logic [31:0] diff;
    logic [32:0] sum;
    logic        t, ill;
    diff = a - b;
    sum  = {1'b0, a} + {1'b0, ~b} + 33'd1;
    in_zf = (diff == 32'd0);
    in_nf = diff[31];
    in_cf = sum[32];
    in_of = (a[31] != b[31]) && (diff[31] != a[31]);
    t = 1'b0;
    ill = 1'b0;
    case (f3)
      3'd0: t = (a == b);
      3'd1: t = (a != b);
      3'd4: t = ($signed(a) < $signed(b));
      3'd5: t = ($signed(a) >= $signed(b));
      3'd6: t = (a < b);
      3'd7: t = (a >= b);
      default: ill = 1'b1;
    endcase
    in_funct3 = f3;
    in_pc = pc;
    in_imm = imm;
    in_valid = 1'b1;
    cur_exp.taken = t;
    cur_exp.illegal = ill;
    cur_exp.target = pc + imm;
    cur_exp.next_pc = t ? pc + imm : pc + 32'd4;
  endtask

  task automatic set_req_flags(input logic [2:0] f3, input logic of, input logic zf, input logic nf,
                               input logic cf, input logic [31:0] pc, input logic [31:0] imm,
                               input logic t, input logic ill);
    in_funct3 = f3;
    in_of = of; in_zf = zf; in_nf = nf; in_cf = cf;
    in_pc = pc;
    in_imm = imm;
    in_valid = 1'b1;
    cur_exp.taken = t;
    cur_exp.illegal = ill;
    cur_exp.target = pc + imm;
    cur_exp.next_pc = t ? pc + imm : pc + 32'd4;
  endtask

  task automatic do_reset();
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_funct3 = 3'd0; in_of = 0; in_zf = 0; in_nf = 0; in_cf = 0;
    in_pc = '0; in_imm = '0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%0b exp=0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%0b exp=1", in_ready); end
    checks++; if ({out_taken, out_illegal} !== 2'b00) begin failures++; $display("FAIL reset_flags got=%b exp=00", {out_taken, out_illegal}); end
    checks++; if ({out_target, out_next_pc} !== 64'd0) begin failures++; $display("FAIL reset_pcs got=%h/%h exp=0/0", out_target, out_next_pc); end
    checks++; if ({stat_total, stat_taken} !== '0) begin failures++; $display("FAIL reset_stats got=%0d/%0d exp=0/0", stat_total, stat_taken); end
  endtask

  task automatic test_beq();
    do_reset();
    out_ready = 1'b1;
    set_req_flags(3'b000, 0, 1, 0, 1, 32'h8000_0000, 32'h10, 1, 0);
    tick();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL beq_latency out_valid got=%0b exp=1", out_valid); end
    checks++; if (out_taken !== 1'b1) begin failures++; $display("FAIL beq_taken got=%0b exp=1", out_taken); end
    checks++; if (out_next_pc !== 32'h8000_0010) begin failures++; $display("FAIL beq_next_pc got=%h exp=80000010", out_next_pc); end
    tick();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL beq_drain out_valid got=%0b exp=0", out_valid); end
  endtask

  task automatic test_signed();
    do_reset();
    out_ready = 1'b1;
    set_req_flags(3'b100, 1, 0, 1, 0, 32'h100, 32'h40, 0, 0);
    tick();
    checks++; if ({out_taken, out_next_pc} !== {1'b0, 32'h104}) begin failures++; $display("FAIL blt got=%0b/%h exp=0/00000104", out_taken, out_next_pc); end
    set_req_flags(3'b110, 0, 0, 0, 1, 32'h200, 32'h40, 0, 0);
    tick();
    checks++; if ({out_taken, out_next_pc} !== {1'b0, 32'h204}) begin failures++; $display("FAIL bltu got=%0b/%h exp=0/00000204", out_taken, out_next_pc); end
    set_req_flags(3'b101, 1, 0, 1, 0, 32'h300, 32'h40, 1, 0);
    tick();
    in_valid = 1'b0;
    checks++; if ({out_taken, out_next_pc} !== {1'b1, 32'h340}) begin failures++; $display("FAIL bge got=%0b/%h exp=1/00000340", out_taken, out_next_pc); end
    tick();
  endtask

  task automatic test_back_to_back();
    do_reset();
    out_ready = 1'b0;
    set_req_flags(3'b000, 0, 1, 0, 1, 32'h1000, 32'h20, 1, 0);
    tick();
    set_req_flags(3'b001, 0, 1, 0, 1, 32'h2000, 32'h20, 0, 0);
    tick();
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL b2b_skid_full in_ready got=%0b exp=0", in_ready); end
    set_req_flags(3'b110, 0, 0, 0, 0, 32'h3000, 32'h30, 1, 0);
    tick();
    checks++; if ({out_valid, in_ready, out_next_pc} !== {2'b10, 32'h1020}) begin failures++; $display("FAIL b2b_hold got=%0b%0b/%h exp=10/00001020", out_valid, in_ready, out_next_pc); end
    out_ready = 1'b1;
    tick();
    checks++; if ({out_valid, in_ready, out_next_pc} !== {2'b11, 32'h2004}) begin failures++; $display("FAIL b2b_second got=%0b%0b/%h exp=11/00002004", out_valid, in_ready, out_next_pc); end
    tick();
    in_valid = 1'b0;
    checks++; if ({out_valid, out_taken, out_next_pc} !== {2'b11, 32'h3030}) begin failures++; $display("FAIL b2b_third got=%0b%0b/%h exp=11/00003030", out_valid, out_taken, out_next_pc); end
    tick();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL b2b_drain out_valid got=%0b exp=0", out_valid); end
  endtask

  task automatic test_illegal();
    do_reset();
    out_ready = 1'b1;
    set_req_flags(3'b011, 0, 1, 0, 1, 32'h400, 32'h80, 0, 1);
    tick();
    in_valid = 1'b0;
    checks++; if ({out_valid, out_illegal, out_taken} !== 3'b110) begin failures++; $display("FAIL illegal_flags got=%b exp=110", {out_valid, out_illegal, out_taken}); end
    checks++; if (out_next_pc !== 32'h404) begin failures++; $display("FAIL illegal_next_pc got=%h exp=00000404", out_next_pc); end
    tick();
    checks++; if (stat_total !== '0) begin failures++; $display("FAIL illegal_stat_total got=%0d exp=0", stat_total); end
  endtask

  task automatic test_wrap();
    do_reset();
    out_ready = 1'b1;
    set_req_flags(3'b000, 0, 1, 0, 1, 32'hFFFF_FFFC, 32'h8, 1, 0);
    tick();
    in_valid = 1'b0;
    checks++; if ({out_target, out_next_pc} !== {32'h4, 32'h4}) begin failures++; $display("FAIL wrap_target got=%h/%h exp=00000004/00000004", out_target, out_next_pc); end
    tick();
  endtask

  task automatic test_flush();
    do_reset();
    out_ready = 1'b0;
    set_req_flags(3'b000, 0, 1, 0, 1, 32'h500, 32'h10, 1, 0);
    tick();
    set_req_flags(3'b000, 0, 1, 0, 1, 32'h600, 32'h10, 1, 0);
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    checks++; if ({out_valid, in_ready} !== 2'b01) begin failures++; $display("FAIL flush_skid_full got=%0b%0b exp=01", out_valid, in_ready); end
    flush = 1'b1;
    set_req_flags(3'b000, 0, 1, 0, 1, 32'h700, 32'h10, 1, 0);
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL flush_discard_input out_valid got=%0b exp=0", out_valid); end
  endtask

  task automatic test_reset_stall();
    do_reset();
    out_ready = 1'b1;
    set_req_flags(3'b000, 0, 1, 0, 1, 32'h800, 32'h10, 1, 0);
    tick();
    set_req_flags(3'b001, 0, 1, 0, 1, 32'h900, 32'h10, 0, 0);
    tick();
    out_ready = 1'b0;
    set_req_flags(3'b000, 0, 1, 0, 1, 32'hA00, 32'h10, 1, 0);
    tick();
    checks++; if (stat_total !== (STATS ? m_total : '0)) begin failures++; $display("FAIL stall_stat_total got=%0d exp=%0d", stat_total, STATS ? m_total : '0); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    in_valid = 1'b0;
    checks++; if ({out_valid, out_taken, out_illegal, out_target, out_next_pc} !== '0) begin failures++; $display("FAIL rst_stall_outputs got=%0b%0b%0b/%h/%h exp=000/0/0", out_valid, out_taken, out_illegal, out_target, out_next_pc); end
    checks++; if ({stat_total, stat_taken} !== '0) begin failures++; $display("FAIL rst_stall_stats got=%0d/%0d exp=0/0", stat_total, stat_taken); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL rst_stall_in_ready got=%0b exp=1", in_ready); end
  endtask

  task automatic test_random();
    logic [31:0] a, b;
    logic        want_valid;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      a = $urandom;
      case ($urandom_range(0, 3))
        0:       b = a;
        1:       b = a ^ 32'h8000_0000;
        default: b = $urandom;
      endcase
      want_valid = $urandom_range(0, 1);
      set_req_ab(3'($urandom_range(0, 7)), a, b, $urandom, $urandom);
      in_valid  = want_valid;
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 29) == 0);
      tick();
      checks++; if (out_valid !== (q.size() > 0)) begin failures++; $display("FAIL rand_out_valid cyc=%0d got=%0b exp=%0b", i, out_valid, q.size() > 0); end
      checks++; if (in_ready !== (q.size() < 2)) begin failures++; $display("FAIL rand_in_ready cyc=%0d got=%0b exp=%0b", i, in_ready, q.size() < 2); end
      if (q.size() > 0) begin
        checks++;
        if ({out_taken, out_illegal, out_target, out_next_pc} !== {q[0].taken, q[0].illegal, q[0].target, q[0].next_pc}) begin
          failures++;
          $display("FAIL rand_data cyc=%0d got=%0b%0b/%h/%h exp=%0b%0b/%h/%h", i, out_taken, out_illegal, out_target, out_next_pc,
                   q[0].taken, q[0].illegal, q[0].target, q[0].next_pc);
        end
      end
      checks++; if ({stat_total, stat_taken} !== (STATS ? {m_total, m_taken} : '0)) begin failures++; $display("FAIL rand_stats cyc=%0d got=%0d/%0d exp=%0d/%0d", i, stat_total, stat_taken, STATS ? m_total : '0, STATS ? m_taken : '0); end
    end
    flush = 1'b0;
    in_valid = 1'b0;
  endtask

  initial begin
    m_total = '0;
    m_taken = '0;
    test_reset();
    test_beq();
    test_signed();
    test_back_to_back();
    test_illegal();
    test_wrap();
    test_flush();
    test_reset_stall();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
